led_pattern_gen: RTL

//  Multi-channel, parametrised LED blink-pattern generator for the baseboard CPLD.
//  One shared prescaler produces a 1/8 s tick; each channel runs its own mode:
//  off, on, 1/2/4 Hz blink, burst-then-pause, or a programmable slow toggle.
//  A SYNC pulse re-phases all channels. Outputs drive front-panel and status LEDs directly.

---
 rtl/led_pattern_gen_pkg.sv | 28 ++
 rtl/led_chan.sv | 101 ++++++++++
 rtl/led_pattern_gen.sv | 56 +++++
 3 files changed

// File: rtl/led_pattern_gen_pkg.sv
// Shared LED mode encodings and small helpers for the LED blink-pattern generator.
package led_pattern_gen_pkg;

    typedef enum logic [2:0] {
        LED_MODE_OFF   = 3'd0,
        LED_MODE_ON    = 3'd1,
        LED_MODE_1HZ   = 3'd2,
        LED_MODE_2HZ   = 3'd3,
        LED_MODE_4HZ   = 3'd4,
        LED_MODE_BURST = 3'd5,
        LED_MODE_SLOW  = 3'd6,
        LED_MODE_RSVD  = 3'd7
    } led_mode_e;

    localparam int PH_W = 6;

    // A programmed period of zero is treated as one tick.
    function automatic logic [4:0] period_floor(input logic [4:0] period);
        logic [4:0] res;
        if (period == 5'd0) begin
            res = 5'd1;
        end else begin
            res = period;
        end
        return res;
    endfunction

endpackage

// File: rtl/led_chan.sv
// One LED channel: stored mode, 6-bit phase counter and registered LED drive.
module led_chan
    import led_pattern_gen_pkg::*;
#(
    parameter bit ACTIVE_LOW = 1'b0
)(
    input  logic       SYSCLK,
    input  logic       RESET,
    input  logic       SYNC,
    input  logic       TICK,
    input  logic [2:0] MODE,
    input  logic [3:0] BURST_CNT,
    input  logic [4:0] PERIOD,
    output logic       LED
);

    led_mode_e         mode_s;
    led_mode_e         ms_r;
    logic [PH_W-1:0]   ph_r;
    logic              led_r;
    logic [PH_W-1:0]   len_s;
    logic [PH_W-1:0]   ph_nxt_s;
    logic [PH_W-1:0]   per_s;
    logic [PH_W-1:0]   burst_span_s;
    logic              lit_s;

    assign mode_s = led_mode_e'(MODE);

    // Cycle length and lit condition of the stored mode at the current phase
    always_comb begin
        per_s        = {1'b0, period_floor(PERIOD)};
        burst_span_s = {1'b0, BURST_CNT, 1'b0};
        len_s        = 6'd1;
        lit_s        = 1'b0;
        case (ms_r)
            LED_MODE_OFF: begin
                len_s = 6'd1;
                lit_s = 1'b0;
            end
            LED_MODE_ON: begin
                len_s = 6'd1;
                lit_s = 1'b1;
            end
            LED_MODE_1HZ: begin
                len_s = 6'd8;
                lit_s = (ph_r < 6'd4);
            end
            LED_MODE_2HZ: begin
                len_s = 6'd4;
                lit_s = (ph_r < 6'd2);
            end
            LED_MODE_4HZ: begin
                len_s = 6'd2;
                lit_s = (ph_r == 6'd0);
            end
            LED_MODE_BURST: begin
                len_s = (per_s > burst_span_s) ? per_s : burst_span_s;
                lit_s = (ph_r < burst_span_s) && !ph_r[0];
            end
            LED_MODE_SLOW: begin
                len_s = {per_s[4:0], 1'b0};
                lit_s = (ph_r < per_s);
            end
            default: begin
                len_s = 6'd1;
                lit_s = 1'b0;
            end
        endcase
    end

    // Phase advance; >= also wraps a phase stranded by a live length shrink
    always_comb begin
        if (ph_r >= (len_s - 6'd1)) begin
            ph_nxt_s = 6'd0;
        end else begin
            ph_nxt_s = ph_r + 6'd1;
        end
    end

    // Stored mode, phase and registered LED drive
    always_ff @(posedge SYSCLK) begin
        if (RESET) begin
            ms_r  <= LED_MODE_OFF;
            ph_r  <= 6'd0;
            led_r <= ACTIVE_LOW;
        end else begin
            ms_r  <= mode_s;
            led_r <= lit_s ^ ACTIVE_LOW;
            if (SYNC || (mode_s != ms_r)) begin
                ph_r <= 6'd0;
            end else if (TICK) begin
                ph_r <= ph_nxt_s;
            end else begin
                ph_r <= ph_r;
            end
        end
    end

    assign LED = led_r;

endmodule

// File: rtl/led_pattern_gen.sv
// Multi-channel LED blink-pattern generator: shared 1/8 s prescaler plus
// N_CH independent pattern channels that SYNC can re-phase together.
module led_pattern_gen
    import led_pattern_gen_pkg::*;
#(
    parameter int CLK_FRQ    = 10_500_000,
    parameter int N_CH       = 4,
    parameter bit ACTIVE_LOW = 1'b0
)(
    input  logic                SYSCLK,
    input  logic                RESET,
    input  logic                SYNC,
    input  logic [3*N_CH-1:0]   MODE,
    input  logic [4*N_CH-1:0]   BURST_CNT,
    input  logic [5*N_CH-1:0]   PERIOD,
    output logic                TICK_8HZ,
    output logic [N_CH-1:0]     LED_O
);

    localparam int               TICK_DIV = CLK_FRQ / 8;
    localparam int               PRE_W    = $clog2(TICK_DIV + 1);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

    logic [PRE_W-1:0] pre_r;
    logic             tick_s;

    assign tick_s   = (pre_r == PRE_LAST);
    assign TICK_8HZ = tick_s;

    // Shared prescaler; SYNC re-phases it together with every channel
    always_ff @(posedge SYSCLK) begin
        if (RESET || SYNC) begin
            pre_r <= PRE_W'(1'b0);
        end else if (tick_s) begin
            pre_r <= PRE_W'(1'b0);
        end else begin
            pre_r <= pre_r + PRE_W'(1'b1);
        end
    end

    for (genvar c = 0; c < N_CH; c++) begin : g_chan
        led_chan #(
            .ACTIVE_LOW (ACTIVE_LOW)
        ) u_chan (
            .SYSCLK    (SYSCLK),
            .RESET     (RESET),
            .SYNC      (SYNC),
            .TICK      (tick_s),
            .MODE      (MODE[3*c +: 3]),
            .BURST_CNT (BURST_CNT[4*c +: 4]),
            .PERIOD    (PERIOD[5*c +: 5]),
            .LED       (LED_O[c])
        );
    end

endmodule
